// File: rtl/button_cmd_encoder.sv
// Button front end: synchronises and debounces raw push-buttons, then turns presses
// (and optional hold-to-repeat) into command codes handed off over valid/ready.
module button_cmd_encoder #(
  parameter int NUM_BTN         = 3,
  parameter int CMD_W           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn,
  output logic [CMD_W-1:0]   cmd,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic               cmd_repeat,
  output logic [CMD_W-1:0]   cmd_level,
  output logic               overflow
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TM_W  = $clog2(TMAX + 1);
  localparam int OWN_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  function automatic logic [CMD_W-1:0] prio_code(input logic [NUM_BTN-1:0] v);
    prio_code = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--)
      if (v[i]) prio_code = CMD_W'(i + 1);
  endfunction

  function automatic logic [OWN_W-1:0] prio_idx(input logic [NUM_BTN-1:0] v);
    prio_idx = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--)
      if (v[i]) prio_idx = OWN_W'(i);
  endfunction

  logic [NUM_BTN-1:0] sync_p0, sync_p1;
  logic [NUM_BTN-1:0] stable_p2, stable_p3;
  logic [DB_W-1:0]    db_cnt [NUM_BTN];

  // Stage 0/1: two-flop synchroniser; stage 2: per-bit debounce; stage 3: edge history
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      stable_p2 <= '0;
      stable_p3 <= '0;
      for (int i = 0; i < NUM_BTN; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0   <= btn;
      sync_p1   <= sync_p0;
      stable_p3 <= stable_p2;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync_p1[i] == stable_p2[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES)) begin
          stable_p2[i] <= sync_p1[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  logic [NUM_BTN-1:0] press_vec;
  logic               press_any;
  logic [OWN_W-1:0]   winner;

  assign press_vec = stable_p2 & ~stable_p3;
  assign press_any = |press_vec;
  assign winner    = prio_idx(press_vec);

  state_t           state, state_nxt;
  logic [OWN_W-1:0] owner, owner_nxt;
  logic [TM_W-1:0]  timer, timer_nxt;
  logic             rep_ev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      owner <= '0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      timer <= timer_nxt;
    end
  end

  // A fresh press always retargets the FSM, so it outranks release and repeat timing
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    timer_nxt = timer;
    rep_ev    = 1'b0;
    if (state != IDLE) timer_nxt = timer + TM_W'(1);
    if (REPEAT_EN == 0) begin
      state_nxt = IDLE;
      timer_nxt = '0;
    end else if (press_any) begin
      state_nxt = DELAY;
      owner_nxt = winner;
      timer_nxt = '0;
    end else if (state != IDLE && !stable_p2[owner]) begin
      state_nxt = IDLE;
      timer_nxt = '0;
    end else if (state == DELAY && timer == TM_W'(REPEAT_DELAY - 1)) begin
      state_nxt = REPEAT;
      rep_ev    = 1'b1;
      timer_nxt = '0;
    end else if (state == REPEAT && timer == TM_W'(REPEAT_RATE - 1)) begin
      rep_ev    = 1'b1;
      timer_nxt = '0;
    end
  end

  logic             ev;
  logic [CMD_W-1:0] ev_code;
  logic             ev_rep;

  assign ev      = press_any | rep_ev;
  assign ev_code = press_any ? CMD_W'(winner) + CMD_W'(1) : CMD_W'(owner) + CMD_W'(1);
  assign ev_rep  = ~press_any;

  // Output stage: back-to-back loads on accept, drop and flag when the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd        <= '0;
      cmd_repeat <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_level  <= '0;
      overflow   <= 1'b0;
    end else begin
      cmd_level <= prio_code(stable_p2);
      if (ev) begin
        if (!cmd_valid || cmd_ready) begin
          cmd        <= ev_code;
          cmd_repeat <= ev_rep;
          cmd_valid  <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

endmodule
